// File: rtl/decode_stage_if.sv
// Bundle of every ID-stage signal except clock and reset: the IF/ID and
// control-unit inputs, register-file read and writeback ports, stall and
// flush controls, and the ID/EX pipeline register outputs.
interface decode_stage_if #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 32
);
  logic [31:0]       InstrD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic              ValidD;
  logic [XLEN-1:0]   ImmD;
  logic [CTRL_W-1:0] CtrlD;
  logic              MemReadD;
  logic              UseRs1D;
  logic              UseRs2D;
  logic [4:0]        A1;
  logic [4:0]        A2;
  logic [XLEN-1:0]   RD1;
  logic [XLEN-1:0]   RD2;
  logic              RegWriteW;
  logic [4:0]        RdW;
  logic [XLEN-1:0]   ResultW;
  logic              FlushE;
  logic              StallF;
  logic              StallD;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [4:0]        Rs1E;
  logic [4:0]        Rs2E;
  logic [4:0]        RdE;
  logic [CTRL_W-1:0] CtrlE;
  logic              MemReadE;
  logic              ValidE;
  logic [CNT_W-1:0]  StallCount;

  // The surrounding pipeline (or a bench) drives the ID-stage inputs
  modport master (
    output InstrD, PCD, PCPlus4D, ValidD, ImmD, CtrlD, MemReadD, UseRs1D, UseRs2D,
           RD1, RD2, RegWriteW, RdW, ResultW, FlushE,
    input  A1, A2, StallF, StallD, RD1E, RD2E, ImmE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, CtrlE, MemReadE, ValidE, StallCount
  );

  // The decode stage consumes those inputs and produces the ID/EX state
  modport slave (
    input  InstrD, PCD, PCPlus4D, ValidD, ImmD, CtrlD, MemReadD, UseRs1D, UseRs2D,
           RD1, RD2, RegWriteW, RdW, ResultW, FlushE,
    output A1, A2, StallF, StallD, RD1E, RD2E, ImmE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, CtrlE, MemReadE, ValidE, StallCount
  );
endinterface

// File: rtl/decode_stage.sv
// ID stage: register-file addressing, write-through bypass of the current
// writeback, load-use hazard detection with one-bubble stall, and the ID/EX
// pipeline register with flush. Also counts load-use stall cycles (saturating).
module decode_stage #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  logic [4:0]        w_a1;
  logic [4:0]        w_a2;
  logic [4:0]        w_rdD;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic              w_hz;
  logic              w_stall;
  logic              w_bubble;

  logic [XLEN-1:0]   r_rd1E;
  logic [XLEN-1:0]   r_rd2E;
  logic [XLEN-1:0]   r_immE;
  logic [XLEN-1:0]   r_pcE;
  logic [XLEN-1:0]   r_pcPlus4E;
  logic [4:0]        r_rs1E;
  logic [4:0]        r_rs2E;
  logic [4:0]        r_rdE;
  logic [CTRL_W-1:0] r_ctrlE;
  logic              r_memReadE;
  logic              r_validE;
  logic [CNT_W-1:0]  r_stallCount;

  assign w_a1  = bus.InstrD[19:15];
  assign w_a2  = bus.InstrD[24:20];
  assign w_rdD = bus.InstrD[11:7];

  // Register file writes at the edge, so a same-cycle writeback must be
  // forwarded here; x0 is hardwired and never forwarded.
  always_comb begin
    w_op1 = bus.RD1;
    w_op2 = bus.RD2;
    if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == w_a1)) w_op1 = bus.ResultW;
    if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == w_a2)) w_op2 = bus.ResultW;
  end

  // Load in EX whose destination is read by the real instruction in ID.
  always_comb begin
    w_hz = bus.ValidD && r_validE && r_memReadE && (r_rdE != 5'd0) &&
           ((bus.UseRs1D && (r_rdE == w_a1)) || (bus.UseRs2D && (r_rdE == w_a2)));
  end

  // A flush kills whatever is in ID anyway, so it cancels the stall.
  assign w_stall  = w_hz && !bus.FlushE;
  assign w_bubble = bus.FlushE || w_hz;

  // ID/EX register: bubble on flush or hazard, otherwise capture ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd1E     <= '0;
      r_rd2E     <= '0;
      r_immE     <= '0;
      r_pcE      <= '0;
      r_pcPlus4E <= '0;
      r_rs1E     <= '0;
      r_rs2E     <= '0;
      r_rdE      <= '0;
      r_ctrlE    <= '0;
      r_memReadE <= 1'b0;
      r_validE   <= 1'b0;
    end else if (w_bubble) begin
      r_rd1E     <= '0;
      r_rd2E     <= '0;
      r_immE     <= '0;
      r_pcE      <= '0;
      r_pcPlus4E <= '0;
      r_rs1E     <= '0;
      r_rs2E     <= '0;
      r_rdE      <= '0;
      r_ctrlE    <= '0;
      r_memReadE <= 1'b0;
      r_validE   <= 1'b0;
    end else begin
      r_rd1E     <= w_op1;
      r_rd2E     <= w_op2;
      r_immE     <= bus.ImmD;
      r_pcE      <= bus.PCD;
      r_pcPlus4E <= bus.PCPlus4D;
      r_rs1E     <= w_a1;
      r_rs2E     <= w_a2;
      r_rdE      <= w_rdD;
      r_ctrlE    <= bus.ValidD ? bus.CtrlD : '0;
      r_memReadE <= bus.MemReadD && bus.ValidD;
      r_validE   <= bus.ValidD;
    end
  end

  // Saturating count of cycles spent stalled on a load-use hazard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stallCount <= '0;
    end else if (w_stall && (r_stallCount != {CNT_W{1'b1}})) begin
      r_stallCount <= r_stallCount + 1'b1;
    end
  end

  assign bus.A1         = w_a1;
  assign bus.A2         = w_a2;
  assign bus.StallF     = w_stall;
  assign bus.StallD     = w_stall;
  assign bus.RD1E       = r_rd1E;
  assign bus.RD2E       = r_rd2E;
  assign bus.ImmE       = r_immE;
  assign bus.PCE        = r_pcE;
  assign bus.PCPlus4E   = r_pcPlus4E;
  assign bus.Rs1E       = r_rs1E;
  assign bus.Rs2E       = r_rs2E;
  assign bus.RdE        = r_rdE;
  assign bus.CtrlE      = r_ctrlE;
  assign bus.MemReadE   = r_memReadE;
  assign bus.ValidE     = r_validE;
  assign bus.StallCount = r_stallCount;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps for reset, bypass, load-use, flush,
// false-hazard and counter saturation, then a randomized run, all checked
// against an instruction-level reference model of the ID/EX register.
module tb_decode_stage;
  localparam int XLEN   = 64;
  localparam int CTRL_W = 12;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;
  int   nAsserts;
  int   nFails;

  decode_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dif ();

  decode_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model of what sits in EX (one record per pipeline slot)
  typedef struct {
    bit               valid;
    bit               memRead;
    logic [4:0]       rs1, rs2, rd;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]  op1, op2, imm, pc, pc4;
  } slot_t;

  slot_t      mE;
  logic [CNT_W-1:0] mCount;
  localparam logic [CNT_W-1:0] CountMax = '1;

  function automatic slot_t emptySlot();
    slot_t s;
    s.valid = 0; s.memRead = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.ctrl = 0;
    s.op1 = 0; s.op2 = 0; s.imm = 0; s.pc = 0; s.pc4 = 0;
    return s;
  endfunction

  // Value of a source register as seen in ID once the writeback is visible
  function automatic logic [XLEN-1:0] readReg(input logic [4:0] idx, input logic [XLEN-1:0] rfData);
    if (dif.RegWriteW && idx != 0 && idx == dif.RdW) return dif.ResultW;
    return rfData;
  endfunction

  function automatic bit modelHazard();
    logic [4:0] s1, s2;
    s1 = dif.InstrD[19:15];
    s2 = dif.InstrD[24:20];
    return dif.ValidD && mE.valid && mE.memRead && mE.rd != 0 &&
           ((dif.UseRs1D && mE.rd == s1) || (dif.UseRs2D && mE.rd == s2));
  endfunction

  function automatic logic [31:0] rType(input int rd, input int rs1, input int rs2);
    logic [4:0] d, a, b;
    d = rd[4:0]; a = rs1[4:0]; b = rs2[4:0];
    return {7'b0, b, a, 3'b000, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] ldType(input int rd, input int rs1);
    logic [4:0] d, a;
    d = rd[4:0]; a = rs1[4:0];
    return {12'h008, a, 3'b011, d, 7'b0000011};
  endfunction

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllE();
    checkOutput("ValidE", dif.ValidE, mE.valid);
    checkOutput("MemReadE", dif.MemReadE, mE.memRead);
    checkOutput("Rs1E", dif.Rs1E, mE.rs1);
    checkOutput("Rs2E", dif.Rs2E, mE.rs2);
    checkOutput("RdE", dif.RdE, mE.rd);
    checkOutput("CtrlE", dif.CtrlE, mE.ctrl);
    checkOutput("RD1E", dif.RD1E, mE.op1);
    checkOutput("RD2E", dif.RD2E, mE.op2);
    checkOutput("ImmE", dif.ImmE, mE.imm);
    checkOutput("PCE", dif.PCE, mE.pc);
    checkOutput("PCPlus4E", dif.PCPlus4E, mE.pc4);
    checkOutput("StallCount", dif.StallCount, mCount);
  endtask

  // One cycle: check ID-side combinational outputs, clock, check EX state
  task automatic applyStimulus();
    slot_t nxt;
    bit    hz, stall;
    #1;
    hz    = modelHazard();
    stall = hz && !dif.FlushE && rst;
    checkOutput("A1", dif.A1, dif.InstrD[19:15]);
    checkOutput("A2", dif.A2, dif.InstrD[24:20]);
    checkOutput("StallF", dif.StallF, stall);
    checkOutput("StallD", dif.StallD, stall);
    nxt = emptySlot();
    if (rst && !dif.FlushE && !hz) begin
      nxt.valid   = dif.ValidD;
      nxt.memRead = dif.ValidD && dif.MemReadD;
      nxt.rs1     = dif.InstrD[19:15];
      nxt.rs2     = dif.InstrD[24:20];
      nxt.rd      = dif.InstrD[11:7];
      nxt.ctrl    = dif.ValidD ? dif.CtrlD : '0;
      nxt.op1     = readReg(dif.InstrD[19:15], dif.RD1);
      nxt.op2     = readReg(dif.InstrD[24:20], dif.RD2);
      nxt.imm     = dif.ImmD;
      nxt.pc      = dif.PCD;
      nxt.pc4     = dif.PCPlus4D;
    end
    @(posedge clk);
    #1;
    mE = nxt;
    if (!rst) mCount = 0;
    else if (stall && mCount != CountMax) mCount = mCount + 1;
    checkAllE();
  endtask

  task automatic setInstr(input logic [31:0] ins, input bit ld, input bit u1, input bit u2);
    dif.InstrD   = ins;
    dif.ValidD   = 1'b1;
    dif.MemReadD = ld;
    dif.UseRs1D  = u1;
    dif.UseRs2D  = u2;
    dif.CtrlD    = 12'(ins[11:0] ^ 12'h5A5);
    dif.ImmD     = {32'h0, ins};
    dif.PCD      = dif.PCD + 64'd4;
    dif.PCPlus4D = dif.PCD + 64'd4;
  endtask

  task automatic randomInputs();
    logic [31:0] ins;
    ins          = $urandom;
    ins[19:15]   = 5'($urandom_range(0, 3));
    ins[24:20]   = 5'($urandom_range(0, 3));
    ins[11:7]    = 5'($urandom_range(0, 3));
    dif.InstrD   = ins;
    dif.ValidD   = ($urandom_range(0, 5) != 0);
    dif.MemReadD = $urandom_range(0, 1) == 1;
    dif.UseRs1D  = $urandom_range(0, 1) == 1;
    dif.UseRs2D  = $urandom_range(0, 1) == 1;
    dif.CtrlD    = 12'($urandom);
    dif.ImmD     = {$urandom, $urandom};
    dif.PCD      = {$urandom, $urandom};
    dif.PCPlus4D = {$urandom, $urandom};
    dif.RD1      = {$urandom, $urandom};
    dif.RD2      = {$urandom, $urandom};
    dif.RegWriteW = $urandom_range(0, 1) == 1;
    dif.RdW      = 5'($urandom_range(0, 3));
    dif.ResultW  = {$urandom, $urandom};
    dif.FlushE   = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int startCount;
    nAsserts = 0;
    nFails   = 0;
    mE       = emptySlot();
    mCount   = 0;
    rst      = 1'b0;
    randomInputs();

    // Reset held with arbitrary inputs
    for (int i = 0; i < 3; i++) begin
      randomInputs();
      applyStimulus();
    end
    checkOutput("rst_ValidE", dif.ValidE, 0);
    checkOutput("rst_StallCount", dif.StallCount, 0);

    // Release reset: first edge captures normally
    rst = 1'b1;
    dif.FlushE = 0; dif.RegWriteW = 0;
    setInstr(rType(5, 1, 2), 0, 1, 1);
    dif.PCD = 64'h100; dif.PCPlus4D = 64'h104;
    applyStimulus();
    checkOutput("rel_PCE", dif.PCE, 64'h100);
    checkOutput("rel_ValidE", dif.ValidE, 1);

    // Write-through bypass on rs1
    setInstr(rType(5, 1, 2), 0, 1, 1);
    dif.RD1 = 64'h11; dif.RD2 = 64'h22;
    dif.RegWriteW = 1; dif.RdW = 1; dif.ResultW = 64'hABCD;
    applyStimulus();
    checkOutput("byp_RD1E", dif.RD1E, 64'hABCD);
    checkOutput("byp_RD2E", dif.RD2E, 64'h22);

    // x0 never bypasses
    setInstr(rType(5, 0, 2), 0, 1, 1);
    dif.RD1 = 64'h33; dif.RdW = 0; dif.ResultW = 64'hFFFF;
    applyStimulus();
    checkOutput("x0_RD1E", dif.RD1E, 64'h33);
    dif.RegWriteW = 0;

    // Load-use: one bubble, then the dependent instruction proceeds
    startCount = int'(dif.StallCount);
    setInstr(ldType(7, 2), 1, 1, 0);
    applyStimulus();
    setInstr(rType(8, 7, 3), 0, 1, 1);
    #1;
    checkOutput("lu_StallF", dif.StallF, 1);
    applyStimulus();
    checkOutput("lu_bubble", dif.ValidE, 0);
    checkOutput("lu_count", dif.StallCount, 64'(startCount + 1));
    applyStimulus();
    checkOutput("lu_retry_Rs1E", dif.Rs1E, 7);
    checkOutput("lu_retry_ValidE", dif.ValidE, 1);

    // Flush takes priority over the stall
    setInstr(ldType(7, 2), 1, 1, 0);
    applyStimulus();
    setInstr(rType(8, 7, 3), 0, 1, 1);
    dif.FlushE = 1;
    #1;
    checkOutput("fl_StallD", dif.StallD, 0);
    applyStimulus();
    checkOutput("fl_ValidE", dif.ValidE, 0);
    checkOutput("fl_count", dif.StallCount, 64'(startCount + 1));
    setInstr(rType(9, 4, 5), 0, 1, 1);
    applyStimulus();
    checkOutput("fl_CtrlE", dif.CtrlE, 0);
    dif.FlushE = 0;

    // No false hazard: load to x0, and an unused rs2 field matching
    setInstr(ldType(0, 2), 1, 1, 0);
    applyStimulus();
    setInstr(rType(8, 0, 0), 0, 1, 1);
    #1;
    checkOutput("nf_x0_StallD", dif.StallD, 0);
    applyStimulus();
    setInstr(ldType(7, 2), 1, 1, 0);
    applyStimulus();
    setInstr(rType(8, 1, 7), 0, 1, 0);
    #1;
    checkOutput("nf_rs2_StallD", dif.StallD, 0);
    applyStimulus();

    // Saturation: enough stalls to reach all-ones, then one more
    for (int i = 0; i < 16; i++) begin
      setInstr(ldType(7, 2), 1, 1, 0);
      applyStimulus();
      setInstr(rType(8, 7, 3), 0, 1, 1);
      applyStimulus();
      applyStimulus();
    end
    checkOutput("sat_full", dif.StallCount, 64'hF);
    setInstr(ldType(7, 2), 1, 1, 0);
    applyStimulus();
    setInstr(rType(8, 7, 3), 0, 1, 1);
    applyStimulus();
    checkOutput("sat_hold", dif.StallCount, 64'hF);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      randomInputs();
      applyStimulus();
    end

    // Asynchronous reset mid-stream clears everything at once
    randomInputs();
    #2;
    rst = 1'b0;
    #1;
    mE = emptySlot();
    mCount = 0;
    checkAllE();
    applyStimulus();
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      randomInputs();
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 64-bit pipelined core, directly upstream of the register file.
- Drives register-file read addresses from the decoded instruction.
- Applies write-through bypass for a same-cycle writeback, detects load-use hazards, and holds the ID/EX pipeline register with stall, flush and bubble insertion.
- Keeps a saturating count of load-use stall cycles.

Parameters:
XLEN, 64, datapath width
CTRL_W, 12, width of opaque control bundle from control unit
CNT_W, 32, width of stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
InstrD  in  32  instruction from IF/ID
PCD  in  XLEN  PC of InstrD
PCPlus4D  in  XLEN  PC+4 of InstrD
ValidD  in  1  IF/ID holds a real instruction
ImmD  in  XLEN  sign-extended immediate from extend unit
CtrlD  in  CTRL_W  control bundle from control unit
MemReadD  in  1  InstrD is a load
UseRs1D  in  1  InstrD reads rs1
UseRs2D  in  1  InstrD reads rs2
A1  out  5  register-file read address 1 = InstrD[19:15]
A2  out  5  register-file read address 2 = InstrD[24:20]
RD1  in  XLEN  register-file read data 1
RD2  in  XLEN  register-file read data 2
RegWriteW  in  1  writeback enable (same as register-file WE3)
RdW  in  5  writeback destination
ResultW  in  XLEN  writeback data
FlushE  in  1  taken branch/jump in EX; kill instruction entering EX
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
RD1E, RD2E, ImmE, PCE, PCPlus4E  out  XLEN  ID/EX data
Rs1E, Rs2E, RdE  out  5  ID/EX register indices (RdE = InstrD[11:7])
CtrlE  out  CTRL_W  ID/EX control
MemReadE  out  1  ID/EX load flag
ValidE  out  1  ID/EX holds a real instruction
StallCount  out  CNT_W  number of load-use stall cycles

Behaviour:
- Reset: asynchronous, active-low on rst. Every ID/EX output and StallCount goes to 0 immediately and stays 0 while rst=0. StallF/StallD read 0 because ValidE=0.
- A1/A2: purely combinational from InstrD, regardless of ValidD.
- Bypass: the register file writes on the clock edge, so a read in the same cycle returns the old value.
  - Op1 = ResultW if RegWriteW & RdW!=0 & RdW==A1, else RD1.
  - Op2 is formed the same way from A2/RD2.
  - x0 never bypasses.
- Load-use hazard (combinational): Hz = ValidD & ValidE & MemReadE & RdE!=0 & ((UseRs1D & RdE==A1) | (UseRs2D & RdE==A2)).
- StallF = StallD = Hz & ~FlushE.
- ID/EX update on each rising clk, in priority order:
  - FlushE=1: insert a bubble. ValidE, MemReadE, CtrlE and RdE go to 0; data fields are don't-care (implement as 0).
  - Hz=1: insert a bubble, as for FlushE.
  - Otherwise: capture Op1, Op2, ImmD, PCD, PCPlus4D, A1, A2, InstrD[11:7], CtrlD, MemReadD & ValidD, and ValidD.
  - When ValidD=0, CtrlE and MemReadE capture 0.
- Latency: 1 cycle D->E. A load-use stall adds exactly 1 bubble, then the held instruction proceeds. On the retry the load is in MEM, so it does not re-trigger.
- StallCount: increments by 1 on each edge where StallD=1 and saturates at all-ones. There is no other clear besides reset.
- Reset deasserted mid-stream: the first edge after deassertion captures normally. No state persists from before reset.

Test Plan:
- Reset: rst=0 with arbitrary inputs for 3 cycles -> all E outputs 0, StallCount=0, StallF=StallD=0. Release rst -> the next edge captures ValidD=1, PCD=0x100 into PCE=0x100.
- Write-through bypass: InstrD=add x5,x1,x2; RD1=0x11; RegWriteW=1, RdW=1, ResultW=0xABCD -> RD1E=0xABCD, RD2E=RD2. Repeat with RdW=0, ResultW=0xFFFF and rs1=x0 -> RD1E=RD1.
- Load-use: cycle n captures ld x7 (MemReadD=1, Rd=7). Cycle n+1 has add x8,x7,x3 with UseRs1D=1 -> StallF=StallD=1, edge gives ValidE=0, StallCount=1. Cycle n+2 has stall=0 and the add is captured with Rs1E=7.
- Flush priority: same hazard as above with FlushE=1 -> StallD=0, bubble in E, StallCount unchanged. Separately, FlushE=1 alone with a valid instruction -> ValidE=0, CtrlE=0.
- No false hazard: load with Rd=x0 followed by a user of x0 -> no stall. Load x7 followed by an instruction with UseRs2D=0 and rs2 field=7 -> no stall.
- Saturation: force StallCount to all-ones via 2^CNT_W stalls (CNT_W=4 build: 16 stalls), one more stall -> stays 0xF.
